dab_setpoint_scheduler: RTL and testbench

- Multi-mode operating-point manager for the DAB modulator. Generalises the two-set switch selection to NUM_MODES run-time-writable parameter sets.
- Delivers t1, t2, phi, fs_DAB and deadtime to the voltage-pattern generator and deadtime/switch block.
- Updates are applied only at PWM period boundaries. phi is slew-limited per period so mode changes cause no current transients.

---
 rtl/dab_setpoint_scheduler_if.sv | 32 +++
 rtl/dab_setpoint_scheduler.sv | 141 ++++++++++++++
 tb/tb_dab_setpoint_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dab_setpoint_scheduler_if.sv
// Control and operating-point bundle between the DAB setpoint scheduler and its host/modulator.
// The master side drives mode selection, period strobes and bank writes; the slave side returns the active operating point.
interface dab_setpoint_scheduler_if #(
    parameter int MODE_W = 2
);
    logic                 enable;
    logic                 period_start;
    logic [MODE_W-1:0]    mode_sel;
    logic                 wr_en;
    logic [MODE_W-1:0]    wr_mode;
    logic [2:0]           wr_addr;
    logic [18:0]          wr_data;

    logic signed [8:0]    t1;
    logic signed [8:0]    t2;
    logic signed [8:0]    phi;
    logic signed [18:0]   fs_DAB;
    logic [7:0]           deadtime;
    logic                 update_ack;
    logic                 busy;
    logic                 wr_err;

    modport master (
        output enable, period_start, mode_sel, wr_en, wr_mode, wr_addr, wr_data,
        input  t1, t2, phi, fs_DAB, deadtime, update_ack, busy, wr_err
    );

    modport slave (
        input  enable, period_start, mode_sel, wr_en, wr_mode, wr_addr, wr_data,
        output t1, t2, phi, fs_DAB, deadtime, update_ack, busy, wr_err
    );
endinterface

// File: rtl/dab_setpoint_scheduler.sv
// Multi-mode DAB operating-point manager: a writable bank of parameter sets, applied at PWM
// period boundaries, with phi slew-limited by PHI_STEP per applied period.
module dab_setpoint_scheduler #(
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 2,
    parameter int PHI_STEP  = 4,
    parameter int FS_MAX    = 150000,
    parameter int DT_MIN    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    dab_setpoint_scheduler_if.slave   bus
);
    localparam logic signed [8:0]  LP_T1_RST = 9'sd223;
    localparam logic signed [8:0]  LP_T2_RST = 9'sd128;
    localparam logic signed [18:0] LP_FS_RST = 19'sd100000;
    localparam logic [7:0]         LP_DT_RST = 8'd20;
    localparam logic signed [9:0]  LP_STEP   = 10'(PHI_STEP);

    typedef enum logic [0:0] {S_IDLE, S_RAMP} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic signed [8:0]      r_t1, r_t2, r_phi;
    logic signed [18:0]     r_fs;
    logic [7:0]             r_dt;
    logic                   r_ack, r_err;

    logic signed [8:0]      w_bank_t1  [NUM_MODES];
    logic signed [8:0]      w_bank_t2  [NUM_MODES];
    logic signed [8:0]      w_bank_phi [NUM_MODES];
    logic signed [18:0]     w_bank_fs  [NUM_MODES];
    logic [7:0]             w_bank_dt  [NUM_MODES];

    logic                   w_wr_ok;
    logic                   w_apply;
    logic signed [8:0]      w_t_clamped, w_phi_clamped;
    logic signed [18:0]     w_fs_clamped;
    logic [7:0]             w_dt_clamped;
    logic [MODE_W-1:0]      w_sel;
    logic signed [9:0]      w_diff;
    logic signed [8:0]      w_phi_step;

    assign w_wr_ok = bus.wr_en && (32'(bus.wr_mode) < NUM_MODES) && (bus.wr_addr <= 3'd4);
    assign w_apply = bus.period_start && bus.enable;

    // Write clamps: angles use the signed low 9 bits, fs/deadtime the unsigned word.
    assign w_t_clamped   = bus.wr_data[8] ? 9'sd0 : $signed(bus.wr_data[8:0]);
    assign w_phi_clamped = (bus.wr_data[8:0] == 9'h100) ? 9'h101 : $signed(bus.wr_data[8:0]);
    assign w_fs_clamped  = (bus.wr_data > 19'(FS_MAX)) ? 19'(FS_MAX) : $signed(bus.wr_data);
    assign w_dt_clamped  = (bus.wr_data < 19'(DT_MIN)) ? 8'(DT_MIN) :
                           (bus.wr_data > 19'd255)     ? 8'hFF       : bus.wr_data[7:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MODES; gi++) begin : g_bank
            logic signed [8:0]  r_e_t1, r_e_t2, r_e_phi;
            logic signed [18:0] r_e_fs;
            logic [7:0]         r_e_dt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_e_t1  <= LP_T1_RST;
                    r_e_t2  <= LP_T2_RST;
                    r_e_phi <= 9'sd0;
                    r_e_fs  <= LP_FS_RST;
                    r_e_dt  <= LP_DT_RST;
                end else if (w_wr_ok && (32'(bus.wr_mode) == gi)) begin
                    case (bus.wr_addr)
                        3'd0:    r_e_t1  <= w_t_clamped;
                        3'd1:    r_e_t2  <= w_t_clamped;
                        3'd2:    r_e_phi <= w_phi_clamped;
                        3'd3:    r_e_fs  <= w_fs_clamped;
                        3'd4:    r_e_dt  <= w_dt_clamped;
                        default: ;
                    endcase
                end
            end

            assign w_bank_t1[gi]  = r_e_t1;
            assign w_bank_t2[gi]  = r_e_t2;
            assign w_bank_phi[gi] = r_e_phi;
            assign w_bank_fs[gi]  = r_e_fs;
            assign w_bank_dt[gi]  = r_e_dt;
        end
    endgenerate

    // Out-of-range mode selections fall back to mode 0.
    assign w_sel  = (32'(bus.mode_sel) < NUM_MODES) ? bus.mode_sel : '0;
    assign w_diff = {w_bank_phi[w_sel][8], w_bank_phi[w_sel]} - {r_phi[8], r_phi};

    always_comb begin
        w_phi_step = w_bank_phi[w_sel];
        if (w_diff > LP_STEP)
            w_phi_step = 9'({r_phi[8], r_phi} + LP_STEP);
        else if (w_diff < -LP_STEP)
            w_phi_step = 9'({r_phi[8], r_phi} - LP_STEP);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_apply && (w_phi_step != w_bank_phi[w_sel])) w_state_next = S_RAMP;
            S_RAMP:  if (w_apply && (w_phi_step == w_bank_phi[w_sel])) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_t1    <= LP_T1_RST;
            r_t2    <= LP_T2_RST;
            r_phi   <= 9'sd0;
            r_fs    <= LP_FS_RST;
            r_dt    <= LP_DT_RST;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_apply;
            r_err   <= bus.wr_en && !w_wr_ok;
            if (w_apply) begin
                r_t1  <= w_bank_t1[w_sel];
                r_t2  <= w_bank_t2[w_sel];
                r_phi <= w_phi_step;
                r_fs  <= w_bank_fs[w_sel];
                r_dt  <= w_bank_dt[w_sel];
            end
        end
    end

    assign bus.t1         = r_t1;
    assign bus.t2         = r_t2;
    assign bus.phi        = r_phi;
    assign bus.fs_DAB     = r_fs;
    assign bus.deadtime   = r_dt;
    assign bus.update_ack = r_ack;
    assign bus.busy       = (r_state == S_RAMP);
    assign bus.wr_err     = r_err;
endmodule

// File: tb/tb_dab_setpoint_scheduler.sv
// Self-checking bench for dab_setpoint_scheduler: directed vector table, corner sequences,
// and randomized traffic against a behavioural model of the operating-point bank.
module tb_dab_setpoint_scheduler;
    localparam int NM = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dab_setpoint_scheduler_if #(.MODE_W(2)) bus();

    dab_setpoint_scheduler #(
        .NUM_MODES(NM), .MODE_W(2), .PHI_STEP(4), .FS_MAX(150000), .DT_MIN(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int b_t1[NM], b_t2[NM], b_phi[NM], b_fs[NM], b_dt[NM];
    int m_t1, m_t2, m_phi, m_fs, m_dt, m_ack, m_busy, m_err;

    typedef struct {
        logic        ps;
        logic [1:0]  msel;
        logic        we;
        logic [1:0]  wm;
        logic [2:0]  wa;
        logic [18:0] wd;
        int          e_phi;
        int          e_busy;
        int          e_ack;
        int          e_fs;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model of one clock edge, evaluated on the inputs presented before that edge.
    task automatic model_edge();
        int sel, tp, d, v, wm, wa;
        if (rst) begin
            for (int i = 0; i < NM; i++) begin
                b_t1[i] = 223; b_t2[i] = 128; b_phi[i] = 0; b_fs[i] = 100000; b_dt[i] = 20;
            end
            m_t1 = 223; m_t2 = 128; m_phi = 0; m_fs = 100000; m_dt = 20;
            m_ack = 0; m_busy = 0; m_err = 0;
        end else begin
            sel = int'(bus.mode_sel);
            if (sel >= NM) sel = 0;
            m_ack = 0;
            if (bus.period_start && bus.enable) begin
                m_t1 = b_t1[sel]; m_t2 = b_t2[sel]; m_fs = b_fs[sel]; m_dt = b_dt[sel];
                tp = b_phi[sel];
                d  = tp - m_phi;
                if (d > 4)       m_phi = m_phi + 4;
                else if (d < -4) m_phi = m_phi - 4;
                else             m_phi = tp;
                m_busy = (m_phi != tp) ? 1 : 0;
                m_ack  = 1;
            end
            m_err = 0;
            if (bus.wr_en) begin
                wm = int'(bus.wr_mode);
                wa = int'(bus.wr_addr);
                if (wm >= NM || wa > 4) begin
                    m_err = 1;
                end else begin
                    v = int'(bus.wr_data[8:0]);
                    if (v >= 256) v = v - 512;
                    case (wa)
                        0: b_t1[wm]  = (v < 0) ? 0 : v;
                        1: b_t2[wm]  = (v < 0) ? 0 : v;
                        2: b_phi[wm] = (v == -256) ? -255 : v;
                        3: b_fs[wm]  = (int'(bus.wr_data) > 150000) ? 150000 : int'(bus.wr_data);
                        default: begin
                            v = int'(bus.wr_data);
                            b_dt[wm] = (v < 2) ? 2 : ((v > 255) ? 255 : v);
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("t1",       int'(bus.t1),         m_t1);
        chk("t2",       int'(bus.t2),         m_t2);
        chk("phi",      int'(bus.phi),        m_phi);
        chk("fs_DAB",   int'(bus.fs_DAB),     m_fs);
        chk("deadtime", int'(bus.deadtime),   m_dt);
        chk("ack",      int'(bus.update_ack), m_ack);
        chk("busy",     int'(bus.busy),       m_busy);
        chk("wr_err",   int'(bus.wr_err),     m_err);
    endtask

    task automatic wr(input int mode, input int addr, input logic [18:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_mode = 2'(mode);
        bus.wr_addr = 3'(addr);
        bus.wr_data = data;
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b1;
        bus.enable = 1'b1; bus.period_start = 1'b0; bus.mode_sel = 2'd0;
        bus.wr_en = 1'b0; bus.wr_mode = 2'd0; bus.wr_addr = 3'd0; bus.wr_data = 19'd0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_t1", int'(bus.t1), 223);
        chk("rst_fs", int'(bus.fs_DAB), 100000);
        chk("rst_dt", int'(bus.deadtime), 20);

        bus.period_start = 1'b1; cyc();
        chk("first_ack", int'(bus.update_ack), 1);
        chk("first_t2",  int'(bus.t2), 128);
        bus.period_start = 1'b0; cyc();
        chk("ack_once", int'(bus.update_ack), 0);

        // Ramp table: write mode 1 then nine consecutive period pulses.
        tbl[0] = '{1'b0, 2'd0, 1'b1, 2'd1, 3'd2, 19'h7FFE0, 0, 0, 0, 100000};
        tbl[1] = '{1'b0, 2'd0, 1'b1, 2'd1, 3'd3, 19'd150000, 0, 0, 0, 100000};
        tbl[2] = '{1'b0, 2'd1, 1'b1, 2'd1, 3'd4, 19'd20, 0, 0, 0, 100000};
        for (int p = 1; p <= 9; p++) begin
            k = (p < 8) ? p : 8;
            tbl[2 + p] = '{1'b1, 2'd1, 1'b0, 2'd0, 3'd0, 19'd0, -4 * k, (p < 8) ? 1 : 0, 1, 150000};
        end
        tbl[12] = '{1'b0, 2'd1, 1'b0, 2'd0, 3'd0, 19'd0, -32, 0, 0, 150000};
        for (int i = 0; i < 13; i++) begin
            bus.period_start = tbl[i].ps;
            bus.mode_sel     = tbl[i].msel;
            bus.wr_en        = tbl[i].we;
            bus.wr_mode      = tbl[i].wm;
            bus.wr_addr      = tbl[i].wa;
            bus.wr_data      = tbl[i].wd;
            cyc();
            chk("tbl_phi",  int'(bus.phi),        tbl[i].e_phi);
            chk("tbl_busy", int'(bus.busy),       tbl[i].e_busy);
            chk("tbl_ack",  int'(bus.update_ack), tbl[i].e_ack);
            chk("tbl_fs",   int'(bus.fs_DAB),     tbl[i].e_fs);
        end
        bus.period_start = 1'b0; bus.wr_en = 1'b0;

        // Clamps and rejected writes.
        wr(2, 3, 19'd200000); chk("wr_ok_err", int'(bus.wr_err), 0);
        wr(2, 4, 19'd0);
        wr(2, 0, 19'h7FFFB);
        wr(2, 6, 19'd77);     chk("rej_addr6", int'(bus.wr_err), 1);
        wr(2, 5, 19'd3);      chk("rej_addr5", int'(bus.wr_err), 1);
        wr(1, 7, 19'd9);      chk("rej_addr7", int'(bus.wr_err), 1);
        cyc();                chk("err_pulse", int'(bus.wr_err), 0);
        bus.mode_sel = 2'd2; bus.period_start = 1'b1; cyc();
        chk("clamp_t1", int'(bus.t1), 0);
        chk("clamp_fs", int'(bus.fs_DAB), 150000);
        chk("clamp_dt", int'(bus.deadtime), 2);
        chk("clamp_phi", int'(bus.phi), -28);
        bus.period_start = 1'b0; cyc();

        // Mid-ramp redirect.
        rst = 1'b1; cyc(); rst = 1'b0;
        wr(3, 2, 19'd64);
        wr(2, 2, 19'h7FFF8);
        bus.mode_sel = 2'd3; bus.period_start = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            cyc(); chk("redir_up", int'(bus.phi), 4 * p);
        end
        bus.mode_sel = 2'd2;
        for (int p = 1; p <= 6; p++) begin
            cyc();
            chk("redir_dn", int'(bus.phi), 16 - 4 * p);
            chk("redir_busy", int'(bus.busy), (p < 6) ? 1 : 0);
        end
        bus.period_start = 1'b0; cyc();

        // Enable low during a ramp freezes outputs and suppresses update_ack.
        wr(1, 2, 19'd40);
        bus.mode_sel = 2'd1; bus.period_start = 1'b1;
        cyc(); cyc(); chk("en_pre", int'(bus.phi), 0);
        bus.enable = 1'b0;
        for (int p = 0; p < 3; p++) begin
            cyc();
            chk("en_hold_phi",  int'(bus.phi), 0);
            chk("en_hold_ack",  int'(bus.update_ack), 0);
            chk("en_hold_busy", int'(bus.busy), 1);
        end
        bus.enable = 1'b1; cyc();
        chk("en_resume", int'(bus.phi), 4);
        bus.period_start = 1'b0; cyc();

        // Reset mid-ramp with a coincident write and period pulse.
        rst = 1'b1; bus.period_start = 1'b1;
        bus.wr_en = 1'b1; bus.wr_mode = 2'd1; bus.wr_addr = 3'd2; bus.wr_data = 19'd100;
        cyc();
        chk("rstmid_phi",  int'(bus.phi), 0);
        chk("rstmid_busy", int'(bus.busy), 0);
        chk("rstmid_ack",  int'(bus.update_ack), 0);
        rst = 1'b0; bus.wr_en = 1'b0; bus.mode_sel = 2'd1;
        cyc();
        chk("rstmid_lost", int'(bus.phi), 0);
        chk("rstmid_t1",   int'(bus.t1), 223);
        bus.period_start = 1'b0; cyc();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst              = ($urandom_range(0, 299) == 0);
            bus.period_start = ($urandom % 2 == 0);
            bus.enable       = ($urandom % 5 != 0);
            bus.mode_sel     = 2'($urandom_range(0, 3));
            bus.wr_en        = ($urandom % 3 == 0);
            bus.wr_mode      = 2'($urandom_range(0, 3));
            bus.wr_addr      = 3'($urandom_range(0, 7));
            case ($urandom % 4)
                0:       bus.wr_data = 19'($urandom);
                1:       bus.wr_data = 19'(int'($urandom_range(0, 80)) - 40);
                2:       bus.wr_data = 19'($urandom_range(140000, 160000));
                default: bus.wr_data = 19'($urandom_range(0, 5));
            endcase
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
